imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, program buffer size in 32-bit words (power of two, 4..64).
REQ-002 SHALL provide parameter LATENCY, default 1, request-to-response delay in cycles (1..3).
REQ-003 SHALL provide parameter BASE_ADDR, default 32'h80000000, byte address of buffer word 0.
REQ-004 SHALL provide parameter NOP_WORD, default 32'h00000013, filler instruction.
REQ-005 clock  in  1  sole clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 io_imem_req_valid  in  1  fetch request from core front end.
REQ-008 io_imem_req_bits_addr  in  32  fetch byte address.
REQ-009 io_imem_resp_valid  out  1  response valid.
REQ-010 io_imem_resp_bits_data  out  32  fetched instruction word.
REQ-011 prog_wr_en  in  1  buffer write strobe.
REQ-012 prog_wr_idx  in  log2(DEPTH)  buffer write word index.
REQ-013 prog_wr_data  in  32  buffer write data.
REQ-014 run_start  in  1  pulse: begin serving program.
REQ-015 run_stop  in  1  pulse: stop serving program.
REQ-016 state  out  2  current FSM state (LOAD=0, RUN=1, DRAIN=2).
REQ-017 fetch_count  out  16  accepted in-range RUN fetches, saturating at 16'hFFFF.
REQ-018 oob_count  out  8  RUN fetches that were misaligned or out of range, saturating at 8'hFF.

Function
REQ-019 SHALL use a 3-state FSM: LOAD -> RUN on run_start; RUN -> DRAIN on run_stop; DRAIN -> LOAD once no response is in flight; encoding 3 is unreachable and SHALL return to LOAD.
REQ-020 SHALL accept buffer writes only in LOAD; writes in RUN or DRAIN SHALL be ignored.
REQ-021 SHALL give run_stop priority when run_start and run_stop are high in the same cycle in LOAD, so the FSM stays in LOAD.
REQ-022 SHALL raise io_imem_resp_valid exactly LATENCY cycles after each cycle with io_imem_req_valid high, with no backpressure; back-to-back requests yield back-to-back responses.
REQ-023 SHALL compute the response data in the request cycle: in RUN, buffer[(addr-BASE_ADDR)>>2] if addr[1:0]==0 and 0 <= addr-BASE_ADDR < 4*DEPTH, else NOP_WORD.
REQ-024 SHALL return NOP_WORD for requests made in LOAD or DRAIN.
REQ-025 SHALL treat the address range check as unsigned 32-bit subtraction, so addresses below BASE_ADDR wrap and are out of range.
REQ-026 SHALL increment fetch_count for each in-range RUN request and oob_count for each out-of-range or misaligned RUN request, each saturating at its maximum.
REQ-027 SHALL drive io_imem_resp_bits_data to NOP_WORD whenever io_imem_resp_valid is low.
REQ-028 SHALL deliver responses already in flight at run_stop unchanged; DRAIN SHALL last at least one cycle and SHALL end when the LATENCY-deep valid pipeline is empty.
REQ-029 SHALL clear both counters on the LOAD -> RUN transition.

Reset
REQ-030 SHALL, on reset low, immediately set: state=LOAD, io_imem_resp_valid=0, io_imem_resp_bits_data=NOP_WORD, fetch_count=0, oob_count=0, and clear the response pipeline.
REQ-031 SHALL preserve buffer contents across reset; responses in flight when reset is asserted SHALL be dropped.

Configuration
REQ-032 SHALL honour macro IMEM_OOB_COUNT_EN: when defined, oob_count operates per REQ-026; when undefined, oob_count SHALL be constant 0 and no counter register is built; REQ-023 behaviour is unchanged in both cases.

Verification
REQ-033 Load idx0=32'h00100093, run_start, request 32'h80000000 -> resp_valid after LATENCY cycles with data 32'h00100093, fetch_count=1.
REQ-034 In RUN, request 32'h80000002 and then 32'h7FFFFFFC -> both responses 32'h00000013, oob_count=2, fetch_count unchanged.
REQ-035 LATENCY=3, requests on 4 consecutive cycles at 0x80000000..0x8000000C -> 4 consecutive responses from buffer words 0..3; run_stop on the last request cycle -> all 4 delivered, then state returns to LOAD.
REQ-036 In RUN, prog_wr_en at idx0 with 32'hDEADBEEF, then fetch 32'h80000000 -> original word returned.
REQ-037 Assert reset low with 2 responses in flight -> resp_valid=0 immediately, state=LOAD, counters 0; run_start after release -> buffer still holds the pre-reset program.
REQ-038 Build without IMEM_OOB_COUNT_EN, issue 5 misaligned RUN fetches -> oob_count stays 0 and all 5 responses are 32'h00000013.

Source files
------------

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder that feeds a core front end from a small
//   program buffer. The buffer is written while the block is in LOAD. Fetches
//   are served from it in RUN. Every request gets exactly one response
//   LATENCY cycles later, with no backpressure.
//
//   Handshake: a request is accepted in every cycle where io_imem_req_valid is
//   high; there is no ready. The matching io_imem_resp_valid pulses exactly
//   LATENCY cycles later. io_imem_resp_bits_data carries NOP_WORD whenever
//   io_imem_resp_valid is low.
//
// Parameters
//   DEPTH      program buffer size in 32-bit words (power of two, 4..64)
//   LATENCY    request-to-response delay in cycles (1..3)
//   BASE_ADDR  byte address of buffer word 0
//   NOP_WORD   filler instruction for misses and non-RUN fetches
//
// Optional feature
//   IMEM_OOB_COUNT_EN  when defined, oob_count counts misaligned or
//                      out-of-range RUN fetches. When undefined, oob_count
//                      is tied to 0.
//
// Ports
//   clock                  sole clock, rising edge
//   reset                  asynchronous, active-low
//   io_imem_req_valid      fetch request
//   io_imem_req_bits_addr  fetch byte address
//   io_imem_resp_valid     response valid
//   io_imem_resp_bits_data fetched instruction word
//   prog_wr_en/idx/data    buffer write port (honoured in LOAD only)
//   run_start / run_stop   control pulses
//   state                  FSM state (LOAD=0, RUN=1, DRAIN=2)
//   fetch_count            in-range RUN fetches, saturating
//   oob_count              misaligned/out-of-range RUN fetches, saturating
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int          DEPTH     = 16,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_imem_req_valid,
  input  logic [31:0]      io_imem_req_bits_addr,
  output logic             io_imem_resp_valid,
  output logic [31:0]      io_imem_resp_bits_data,
  input  logic             prog_wr_en,
  input  logic [IDX_W-1:0] prog_wr_idx,
  input  logic [31:0]      prog_wr_data,
  input  logic             run_start,
  input  logic             run_stop,
  output logic [1:0]       state,
  output logic [15:0]      fetch_count,
  output logic [7:0]       oob_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  state_t state_q, state_d;

  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] vpipe;
  logic [31:0]        dpipe [LATENCY];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      req_data;
  logic             run_fetch;
  logic             enter_run;
  logic [15:0]      fetch_q;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
  // and fail the range check.
  assign offset    = io_imem_req_bits_addr - BASE_ADDR;
  assign in_range  = (io_imem_req_bits_addr[1:0] == 2'b00) && (offset < SPAN);
  assign rd_idx    = offset[IDX_W+1:2];
  assign run_fetch = io_imem_req_valid && (state_q == S_RUN);
  assign req_data  = (run_fetch && in_range) ? mem[rd_idx] : NOP_WORD;
  assign enter_run = (state_q == S_LOAD) && (state_d == S_RUN);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // run_stop wins over a simultaneous run_start.
      S_LOAD:  if (run_start && !run_stop) state_d = S_RUN;
      S_RUN:   if (run_stop) state_d = S_DRAIN;
      // Leave DRAIN only once every earlier response has left the pipeline.
      // The state register guarantees at least one cycle in DRAIN.
      S_DRAIN: if (vpipe == '0) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Program buffer. It has no reset, so its contents survive reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (prog_wr_en && (state_q == S_LOAD)) mem[prog_wr_idx] <= prog_wr_data;
  end

  // ---------------------------------------------------------------------------
  // Response pipeline. Data is resolved in the request cycle. Empty slots
  // carry NOP_WORD, so the output data is NOP whenever valid is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      for (int i = 0; i < LATENCY; i++) dpipe[i] <= NOP_WORD;
    end else begin
      vpipe[0] <= io_imem_req_valid;
      dpipe[0] <= io_imem_req_valid ? req_data : NOP_WORD;
      for (int i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign io_imem_resp_valid     = vpipe[LATENCY-1];
  assign io_imem_resp_bits_data = dpipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Counters. Both are cleared on entry to RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_q <= '0;
    end else if (enter_run) begin
      fetch_q <= '0;
    end else if (run_fetch && in_range && (fetch_q != 16'hFFFF)) begin
      fetch_q <= fetch_q + 16'd1;
    end
  end

  assign fetch_count = fetch_q;

`ifdef IMEM_OOB_COUNT_EN
  logic [7:0] oob_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oob_q <= '0;
    end else if (enter_run) begin
      oob_q <= '0;
    end else if (run_fetch && !in_range && (oob_q != 8'hFF)) begin
      oob_q <= oob_q + 8'd1;
    end
  end

  assign oob_count = oob_q;
`else
  assign oob_count = 8'd0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder. It uses DEPTH=16 and LATENCY=3, so the
//   pipelining and drain behaviour can be observed. Inputs change 1 ns after
//   the rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_responder;

  localparam int          DEPTH   = 16;
  localparam int          LATENCY = 3;
  localparam logic [31:0] NOP     = 32'h00000013;
`ifdef IMEM_OOB_COUNT_EN
  localparam bit OOB_ON = 1'b1;
`else
  localparam bit OOB_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic        run_start;
  logic        run_stop;
  logic [1:0]  state;
  logic [15:0] fetch_count;
  logic [7:0]  oob_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] prog [4];
  logic [31:0] exp_q [$];
  logic [31:0] mis_addr [5];

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  imem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_imem_req_valid      (req_valid),
    .io_imem_req_bits_addr  (req_addr),
    .io_imem_resp_valid     (resp_valid),
    .io_imem_resp_bits_data (resp_data),
    .prog_wr_en             (wr_en),
    .prog_wr_idx            (wr_idx),
    .prog_wr_data           (wr_data),
    .run_start              (run_start),
    .run_stop               (run_stop),
    .state                  (state),
    .fetch_count            (fetch_count),
    .oob_count              (oob_count)
  );

  // ---------------------------------------------------------------------------
  // Driver and check tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oobx(input int n);
    return OOB_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic write_word(input logic [3:0] idx, input logic [31:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  // Issue a single fetch. Valid must stay low for LATENCY-1 cycles and then
  // rise with the expected data. The expected word is taken from the
  // scoreboard queue.
  task automatic fetch1(input string tag, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(data);
    req_valid = 1'b1; req_addr = addr;
    step();
    req_valid = 1'b0;
    chk({tag, "_v_early1"}, {31'd0, resp_valid}, 32'd0);
    step();
    chk({tag, "_v_early2"}, {31'd0, resp_valid}, 32'd0);
    step();
    chk({tag, "_v"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_data"}, resp_data, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    prog[0] = 32'h00100093; prog[1] = 32'h00200113;
    prog[2] = 32'h00300193; prog[3] = 32'h00400213;
    mis_addr[0] = 32'h80000001; mis_addr[1] = 32'h80000002;
    mis_addr[2] = 32'h80000003; mis_addr[3] = 32'h80000005;
    mis_addr[4] = 32'h8000000E;

    reset = 1'b0; req_valid = 1'b0; req_addr = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    run_start = 1'b0; run_stop = 1'b0;

    // Reset state
    step(); step();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data",  resp_data, NOP);
    chk("rst_fetch", {16'd0, fetch_count}, 32'd0);
    chk("rst_oob",   {24'd0, oob_count}, 32'd0);
    reset = 1'b1;
    step();

    // Load the program, including the last word, for the boundary fetch.
    for (int i = 0; i < 4; i++) write_word(4'(i), prog[i]);
    write_word(4'd15, 32'h0000006F);

    // A simultaneous start and stop keeps the FSM in LOAD.
    run_start = 1'b1; run_stop = 1'b1;
    step();
    run_start = 1'b0; run_stop = 1'b0;
    chk("start_stop_load", {30'd0, state}, 32'd0);

    run_start = 1'b1;
    step();
    run_start = 1'b0;
    chk("enter_run", {30'd0, state}, 32'd1);

    // Basic in-range fetch
    fetch1("fetch0", 32'h80000000, prog[0]);
    chk("fetch0_cnt", {16'd0, fetch_count}, 32'd1);
    step();
    chk("idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_data",  resp_data, NOP);

    // Back-to-back misaligned and below-base fetches
    req_valid = 1'b1; req_addr = 32'h80000002; step();
    req_addr = 32'h7FFFFFFC; step();
    req_valid = 1'b0;
    step();
    chk("mis_v",    {31'd0, resp_valid}, 32'd1);
    chk("mis_data", resp_data, NOP);
    step();
    chk("wrap_v",    {31'd0, resp_valid}, 32'd1);
    chk("wrap_data", resp_data, NOP);
    chk("oob_2",     {24'd0, oob_count}, oobx(2));
    chk("fetch_kept", {16'd0, fetch_count}, 32'd1);

    // Range boundaries: the last word is in range; the next word is not.
    fetch1("last_word", 32'h8000003C, 32'h0000006F);
    fetch1("past_end",  32'h80000040, NOP);
    chk("bound_fetch", {16'd0, fetch_count}, 32'd2);
    chk("bound_oob",   {24'd0, oob_count}, oobx(3));

    // A write in RUN is ignored.
    write_word(4'd0, 32'hDEADBEEF);
    fetch1("run_wr_ignored", 32'h80000000, prog[0]);

    // Four back-to-back fetches, with run_stop on the last request cycle
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'h80000000 + 32'(4 * i);
      run_stop  = (i == 3);
      step();
      if (i >= 2) chk("b2b_data", resp_data, prog[i-2]);
      if (i >= 2) chk("b2b_v", {31'd0, resp_valid}, 32'd1);
    end
    req_valid = 1'b0; run_stop = 1'b0;
    chk("drain_state", {30'd0, state}, 32'd2);
    step();
    chk("b2b_data2", resp_data, prog[2]);
    step();
    chk("b2b_data3", resp_data, prog[3]);
    chk("drain_hold", {30'd0, state}, 32'd2);
    for (int k = 0; k < 6 && state != 2'd0; k++) step();
    chk("back_to_load", {30'd0, state}, 32'd0);
    chk("b2b_fetch", {16'd0, fetch_count}, 32'd7);

    // Fetches in LOAD return NOP and leave the counters unchanged.
    fetch1("load_nop", 32'h80000004, NOP);
    chk("load_fetch_kept", {16'd0, fetch_count}, 32'd7);
    chk("load_oob_kept",   {24'd0, oob_count}, oobx(3));

    // The counters clear on entry to RUN.
    run_start = 1'b1; step(); run_start = 1'b0;
    chk("clr_state", {30'd0, state}, 32'd1);
    chk("clr_fetch", {16'd0, fetch_count}, 32'd0);
    chk("clr_oob",   {24'd0, oob_count}, 32'd0);

    // Reset with two responses in flight
    req_valid = 1'b1; req_addr = 32'h80000004; step();
    req_addr = 32'h80000008; step();
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_data",  resp_data, NOP);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_fetch", {16'd0, fetch_count}, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("dropped_v", {31'd0, resp_valid}, 32'd0);
    step();
    chk("dropped_v2", {31'd0, resp_valid}, 32'd0);
    run_start = 1'b1; step(); run_start = 1'b0;
    fetch1("post_reset", 32'h80000004, prog[1]);
    chk("post_reset_cnt", {16'd0, fetch_count}, 32'd1);

    // Five misaligned back-to-back fetches
    for (int i = 0; i < 7; i++) begin
      req_valid = (i < 5);
      req_addr  = (i < 5) ? mis_addr[i] : 32'h0;
      step();
      if (i >= 2) chk("mis5_v", {31'd0, resp_valid}, 32'd1);
      if (i >= 2) chk("mis5_data", resp_data, NOP);
    end
    req_valid = 1'b0;
    chk("mis5_oob",   {24'd0, oob_count}, oobx(5));
    chk("mis5_fetch", {16'd0, fetch_count}, 32'd1);

    run_stop = 1'b1; step(); run_stop = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
